// File: rtl/byte_lane_data_mem.sv
// rtl/byte_lane_data_mem.sv - byte-lane data RAM with unaligned access, IO registers and valid/ready handshake
module byte_lane_data_mem #(
  parameter int          ADDR_W      = 11,
  parameter int          LANES       = 4,
  parameter logic [31:0] IO_BASE     = 32'h7F0,
  parameter int          NUM_IO      = 4,
  parameter int          IO_W        = 16,
  parameter bit          IO_INVERT   = 1'b1,
  parameter              INIT_PREFIX = "memory_init/eab-init"
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clk_enable,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [31:0]            req_addr,
  input  logic [1:0]             req_size,
  input  logic                   req_sext,
  input  logic [8*LANES-1:0]     req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [8*LANES-1:0]     rsp_rdata,
  output logic                   rsp_fault,
  output logic [NUM_IO*IO_W-1:0] io_out
);

  localparam int          OFF_W  = $clog2(LANES);
  localparam int          WORD_W = ADDR_W - OFF_W;
  localparam int          DEPTH  = 2 ** WORD_W;
  localparam int          DW     = 8 * LANES;
  localparam int          IDX_W  = (NUM_IO > 1) ? $clog2(NUM_IO) : 1;
  localparam logic [31:0] IO_END = IO_BASE + 32'(LANES * NUM_IO);

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, RESP = 2'd2} state_t;

  state_t state_q, state_d;

  logic [OFF_W-1:0]  off;
  logic [WORD_W-1:0] word;
  logic [3:0]        nbytes;
  logic [32:0]       last_addr;
  logic              io_hit, fault, accept, ram_we;
  logic [IDX_W-1:0]  io_idx;

  logic [OFF_W-1:0]  lane_rel  [LANES];
  logic [WORD_W-1:0] lane_addr [LANES];
  logic [7:0]        lane_wdata[LANES];
  logic [LANES-1:0]  lane_we;
  logic [DW-1:0]     rd_word;

  logic [OFF_W-1:0]  off_q;
  logic [3:0]        nbytes_q;
  logic              sext_q, is_io_q;
  logic [IDX_W-1:0]  io_idx_q;
  logic [IO_W-1:0]   io_q [NUM_IO];

  logic [DW-1:0]     load_data;
  logic [OFF_W-1:0]  src, src_top;
  logic              sign;

  // Request decode: access width, fault conditions and IO overlay hit
  always_comb begin
    off  = req_addr[OFF_W-1:0];
    word = req_addr[ADDR_W-1:OFF_W];
    case (req_size)
      2'd0:    nbytes = 4'd1;
      2'd1:    nbytes = 4'd2;
      default: nbytes = 4'((LANES < 4) ? LANES : 4);
    endcase
    last_addr = {1'b0, req_addr} + 33'(nbytes) - 33'd1;
    io_hit    = (req_addr >= IO_BASE) && (req_addr < IO_END);
    io_idx    = IDX_W'((req_addr - IO_BASE) >> OFF_W);
    fault     = (req_size == 2'd3) || (|last_addr[32:ADDR_W]) ||
                (io_hit && ((req_size != 2'd2) || (off != '0)));
    accept    = (state_q == IDLE) && req_valid && clk_enable;
    ram_we    = accept && req_we && !fault && !io_hit;
  end

  // Lanes below the offset belong to the following word
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      lane_rel[k]   = OFF_W'(k) - off;
      lane_we[k]    = ram_we && (4'(lane_rel[k]) < nbytes);
      lane_addr[k]  = (OFF_W'(k) < off) ? word + WORD_W'(1) : word;
      lane_wdata[k] = req_wdata[8*lane_rel[k] +: 8];
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    localparam LANE_FILE = {INIT_PREFIX, "-", 8'(8'h30 + k), ".mif"};
    (* ram_init_file = LANE_FILE *) logic [7:0] mem [DEPTH];
    logic [7:0] rd_q;

    always_ff @(posedge clk) begin
      if (lane_we[k]) mem[lane_addr[k]] <= lane_wdata[k];
      if (accept) rd_q <= mem[lane_addr[k]];
    end

    assign rd_word[8*k +: 8] = rd_q;
  end

  // Un-swizzle lanes back into request byte order, then extend
  always_comb begin
    load_data = '0;
    src       = '0;
    src_top   = off_q + OFF_W'(nbytes_q - 4'd1);
    sign      = sext_q & rd_word[8*src_top + 7];
    if (is_io_q) begin
      load_data = DW'(io_q[io_idx_q]);
    end else begin
      for (int j = 0; j < LANES; j++) begin
        src = off_q + OFF_W'(j);
        if (4'(j) < nbytes_q) load_data[8*j +: 8] = rd_word[8*src +: 8];
        else                  load_data[8*j +: 8] = {8{sign}};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else if (clk_enable) state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = (req_we || fault) ? RESP : RD;
      end
      RD:   state_d = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata <= '0;
      rsp_fault <= 1'b0;
      off_q     <= '0;
      nbytes_q  <= '0;
      sext_q    <= 1'b0;
      is_io_q   <= 1'b0;
      io_idx_q  <= '0;
      for (int i = 0; i < NUM_IO; i++) io_q[i] <= '0;
    end else if (clk_enable) begin
      if (accept) begin
        rsp_fault <= fault;
        rsp_rdata <= '0;
        off_q     <= off;
        nbytes_q  <= nbytes;
        sext_q    <= req_sext;
        is_io_q   <= io_hit;
        io_idx_q  <= io_idx;
        if (req_we && io_hit && !fault) io_q[io_idx] <= req_wdata[IO_W-1:0];
      end
      if (state_q == RD) rsp_rdata <= load_data;
    end
  end

  // Stored values stay true; inversion is only for the external display
  for (genvar i = 0; i < NUM_IO; i++) begin : g_io
    assign io_out[i*IO_W +: IO_W] = IO_INVERT ? ~io_q[i] : io_q[i];
  end

endmodule

// File: doc/byte_lane_data_mem.md
Name: byte_lane_data_mem

Overview:
- Parametrised successor to the CPU's data memory.
- Provides byte-lane RAM with unaligned access. Misaligned accesses are split across adjacent words in a single RAM access, using per-lane word addresses.
- Provides load truncation and sign extension, a memory-mapped bank of output registers, and address-fault detection.
- Adds a valid/ready request/response handshake so the pipeline can stall on memory.
- Sits between the execute stage and the writeback mux.

Parameters:
- ADDR_W, 11: number of byte-address bits decoded. Memory size is 2^ADDR_W bytes.
- LANES, 4: bytes per word. Must be a power of two, 2 to 8.
- IO_BASE, 32'h7F0: byte address of IO register 0. IO register i is at IO_BASE + LANES*i. Must be LANES-aligned.
- NUM_IO, 4: number of IO registers.
- IO_W, 16: stored width of each IO register, at most 8*LANES.
- IO_INVERT, 1: when 1, io_out drives the bit-inverted stored value (active-low displays).
- INIT_PREFIX, "memory_init/eab-init": prefix for the per-lane init files. The file for lane k is INIT_PREFIX-k.mif.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- clk_enable  in  1  global stall; when 0 all state holds and no RAM write occurs
- req_valid  in  1  request present
- req_ready  out  1  block accepts the request this cycle
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address; any alignment
- req_size  in  2  access size: 0 = byte, 1 = half, 2 = word; 3 is reserved and faults
- req_sext  in  1  sign-extend the load result
- req_wdata  in  8*LANES  store data, LSB-justified
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes the response
- rsp_rdata  out  8*LANES  load result, zero for stores and faults
- rsp_fault  out  1  the access was rejected
- io_out  out  NUM_IO*IO_W  IO register outputs; register i occupies bits [i*IO_W +: IO_W]

Behaviour:
- Clocking: one clock, clk. Reset is asynchronous and active-low on rst_n. Every register update is qualified by clk_enable, except reset.
- Reset values: state IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_fault = 0. Every io_out field resets to all-ones if IO_INVERT = 1, else zero. RAM contents are not reset.
- FSM states:
  - IDLE: req_ready = 1. A request is accepted when req_valid & clk_enable.
    - Accepted store or fault → RESP.
    - Accepted load → RD.
  - RD: the RAM read is in flight. The lane outputs are swizzled, masked, extended and registered into rsp_rdata → RESP.
  - RESP: rsp_valid = 1 and req_ready = 0. Outputs hold stable until rsp_ready & clk_enable → IDLE.
- Latency: store accept to rsp_valid is 1 cycle. Load accept to rsp_valid is 2 cycles. At most one request is outstanding, so peak throughput is one access per 2 cycles for stores and per 3 cycles for loads.
- Lane mapping:
  - Let off = req_addr[log2(LANES)-1:0] and word = req_addr[ADDR_W-1:log2(LANES)].
  - Lane k holds byte k of each word.
  - Lane k uses address word+1 if k < off, else word.
  - Request byte j maps to lane (off+j) mod LANES.
  - Store write enables cover exactly the lanes selected by req_size (1, 2 or 4 bytes), gated by req_we and clk_enable.
- Load result:
  - Bytes beyond the access size are zero, or copies of the top accessed bit when req_sext = 1.
  - Word size with LANES = 8 returns the low 4 bytes, extended.
- Faults (rsp_fault = 1, no RAM write, no IO write, rsp_rdata = 0):
  - req_size = 3.
  - Access with last byte address ≥ 2^ADDR_W. There is no wrap-around past the top of memory.
  - IO-region access that is not word size or not LANES-aligned.
  - Any req_addr bits above ADDR_W set.
- IO region overlay:
  - An address in [IO_BASE, IO_BASE + LANES*NUM_IO) targets the IO registers instead of RAM. The RAM is not written.
  - A store sets the register to req_wdata[IO_W-1:0] on the accept edge.
  - A load returns the stored (non-inverted) value, zero-extended.
- Simultaneous events:
  - A request presented while in RD or RESP is not accepted (req_ready = 0). The requester holds it.
  - clk_enable = 0 in RESP keeps rsp_valid asserted but blocks the handshake.
- Reset mid-operation: any state → IDLE immediately. A pending response is discarded. A store already accepted on a prior edge remains committed.

Test Plan:
- Aligned word: store 0xDEADBEEF at 0x010 → ack after 1 cycle, rsp_fault = 0. Load word at 0x010 → rsp_rdata 0xDEADBEEF, 2 cycles after accept.
- Misaligned half crossing words: store half 0xA5C3 at 0x013 → byte 0x013 = 0xC3, byte 0x014 = 0xA5, bytes 0x010–0x012 unchanged. Load signed half at 0x013 → 0xFFFFA5C3. Load unsigned half at 0x013 → 0x0000A5C3.
- Sign extension: store byte 0x80 at 0x021. Load byte sext at 0x021 → 0xFFFFFF80. Load byte zext at 0x021 → 0x00000080.
- IO: store word 0x00001234 at 0x7F4 → io_out[31:16] = 0xEDCB (IO_INVERT = 1). Load at 0x7F4 → 0x00001234. RAM byte 0x7F4 unchanged. Byte store at 0x7F5 → rsp_fault = 1 and io_out unchanged.
- Faults: word load at 0x7FE → rsp_fault = 1, rdata 0. Load with req_size = 3 → fault. Store to 0x1000 → fault, memory unchanged.
- Backpressure/reset:
  - Hold rsp_ready = 0 for 5 cycles after a load → rsp_valid and rsp_rdata stable, req_ready = 0.
  - Drop clk_enable during RD → no progress.
  - Assert rst_n = 0 in RESP → rsp_valid = 0 and req_ready = 1 immediately, io_out = 0xFFFF per field.
